// File: rtl/bsg_vanilla_pkg.sv
// Shared definitions for the vanilla decode queue: RV32 opcode / funct7
// constants and the compact decoded control record.
package bsg_vanilla_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] RV32_LUI_OP      = 7'b0110111;
    localparam logic [6:0] RV32_AUIPC_OP    = 7'b0010111;
    localparam logic [6:0] RV32_JAL_OP      = 7'b1101111;
    localparam logic [6:0] RV32_JALR_OP     = 7'b1100111;
    localparam logic [6:0] RV32_BRANCH_OP   = 7'b1100011;
    localparam logic [6:0] RV32_LOAD_OP     = 7'b0000011;
    localparam logic [6:0] RV32_STORE_OP    = 7'b0100011;
    localparam logic [6:0] RV32_OP_OP       = 7'b0110011;
    localparam logic [6:0] RV32_OP_IMM_OP   = 7'b0010011;
    localparam logic [6:0] RV32_AMO_OP      = 7'b0101111;
    localparam logic [6:0] RV32_OP_FP_OP    = 7'b1010011;
    localparam logic [6:0] RV32_LOAD_FP_OP  = 7'b0000111;
    localparam logic [6:0] RV32_STORE_FP_OP = 7'b0100111;
    localparam logic [6:0] RV32_MISC_MEM_OP = 7'b0001111;
    localparam logic [6:0] RV32_SYSTEM_OP   = 7'b1110011;

    // funct7 values of interest
    localparam logic [6:0] RV32_MD_FUNCT7      = 7'b0000001;
    localparam logic [6:0] RV32_FCMP_FUNCT7    = 7'b1010000;
    localparam logic [6:0] RV32_FMV_X_W_FUNCT7 = 7'b1110000;
    localparam logic [6:0] RV32_FCVT_W_FUNCT7  = 7'b1100000;
    localparam logic [6:0] RV32_FCVT_S_FUNCT7  = 7'b1101000;
    localparam logic [6:0] RV32_FMV_W_X_FUNCT7 = 7'b1111000;

    // AMO funct5 (funct7[6:2]) groups that read rs2
    localparam logic [4:0] RV32_AMOSWAP_FUNCT5 = 5'b00001;
    localparam logic [4:0] RV32_AMOOR_FUNCT5   = 5'b01000;

    typedef struct packed {
        logic writes_rf;
        logic reads_rf1;
        logic reads_rf2;
        logic writes_fp_rf;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
        logic is_md;
        logic is_fence;
        logic illegal;
    } decode_lite_s;

endpackage

// File: rtl/vanilla_decode_lite.sv
// Combinational RV32 decoder producing the compact decode_lite_s record.
module vanilla_decode_lite
    import bsg_vanilla_pkg::*;
(
    input  logic [31:0]  instr_i,
    output decode_lite_s decode_o
);

    logic [6:0] op;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs2;
    logic       rd_nz;
    logic       fp_int_dest;
    logic       unused_rs1;

    assign op     = instr_i[6:0];
    assign funct7 = instr_i[31:25];
    assign funct3 = instr_i[14:12];
    assign rs2    = instr_i[24:20];
    assign rd_nz  = (instr_i[11:7] != 5'd0);
    assign unused_rs1 = ^instr_i[19:15];

    // FP ops whose result lands in the integer register file
    assign fp_int_dest = (funct7 == RV32_FCMP_FUNCT7)
                       | ((funct7 == RV32_FMV_X_W_FUNCT7) & (rs2 == 5'd0))
                       | (funct7 == RV32_FCVT_W_FUNCT7);

    // Opcode-driven decode of all record fields
    always_comb begin
        decode_o = '0;
        case (op)
            RV32_LUI_OP, RV32_AUIPC_OP: begin
                decode_o.writes_rf = rd_nz;
            end
            RV32_JAL_OP: begin
                decode_o.writes_rf = rd_nz;
                decode_o.is_jal    = 1'b1;
            end
            RV32_JALR_OP: begin
                decode_o.writes_rf = rd_nz;
                decode_o.reads_rf1 = 1'b1;
                decode_o.is_jalr   = 1'b1;
            end
            RV32_BRANCH_OP: begin
                decode_o.reads_rf1 = 1'b1;
                decode_o.reads_rf2 = 1'b1;
                decode_o.is_branch = 1'b1;
            end
            RV32_LOAD_OP: begin
                decode_o.writes_rf = rd_nz;
                decode_o.reads_rf1 = 1'b1;
                decode_o.is_load   = 1'b1;
            end
            RV32_STORE_OP: begin
                decode_o.reads_rf1 = 1'b1;
                decode_o.reads_rf2 = 1'b1;
                decode_o.is_store  = 1'b1;
            end
            RV32_OP_OP: begin
                decode_o.writes_rf = rd_nz;
                decode_o.reads_rf1 = 1'b1;
                decode_o.reads_rf2 = 1'b1;
                decode_o.is_md     = (funct7 == RV32_MD_FUNCT7);
            end
            RV32_OP_IMM_OP: begin
                decode_o.writes_rf = rd_nz;
                decode_o.reads_rf1 = 1'b1;
            end
            RV32_AMO_OP: begin
                decode_o.writes_rf = rd_nz;
                decode_o.reads_rf1 = 1'b1;
                decode_o.reads_rf2 = (funct7[6:2] == RV32_AMOSWAP_FUNCT5)
                                   | (funct7[6:2] == RV32_AMOOR_FUNCT5);
            end
            RV32_LOAD_FP_OP: begin
                decode_o.reads_rf1    = 1'b1;
                decode_o.writes_fp_rf = 1'b1;
                decode_o.is_load      = 1'b1;
            end
            RV32_STORE_FP_OP: begin
                decode_o.reads_rf1 = 1'b1;
                decode_o.is_store  = 1'b1;
            end
            RV32_OP_FP_OP: begin
                decode_o.writes_rf    = fp_int_dest;
                decode_o.writes_fp_rf = ~fp_int_dest;
                decode_o.reads_rf1    = (funct7 == RV32_FCVT_S_FUNCT7)
                                      | (funct7 == RV32_FMV_W_X_FUNCT7);
            end
            RV32_MISC_MEM_OP: begin
                decode_o.is_fence = (funct3 == 3'b000);
            end
            RV32_SYSTEM_OP: begin
                decode_o.illegal = 1'b0;
            end
            default: begin
                decode_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vanilla_decode_buffer.sv
// Registered decode queue between fetch and issue. Instructions are decoded
// on the write side and stored with their PC in a circular buffer.
// Optional same-cycle bypass when empty: define VANILLA_DECODE_BUF_BYPASS_EN.
module vanilla_decode_buffer
    import bsg_vanilla_pkg::*;
#(
    parameter int unsigned depth_p    = 4,
    parameter int unsigned pc_width_p = 22
)
(
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    input  logic [31:0]                    instr_i,
    input  logic [pc_width_p-1:0]          pc_i,
    output logic                           ready_o,
    output logic                           v_o,
    output decode_lite_s                   decode_o,
    output logic [31:0]                    instr_o,
    output logic [pc_width_p-1:0]          pc_o,
    input  logic                           yumi_i,
    input  logic                           flush_i,
    output logic [$clog2(depth_p+1)-1:0]   count_o
);

    localparam int unsigned ptr_w_lp = $clog2(depth_p);
    localparam int unsigned cnt_w_lp = $clog2(depth_p+1);

    decode_lite_s            dec_li;
    decode_lite_s            dec_mem   [depth_p];
    logic [31:0]             instr_mem [depth_p];
    logic [pc_width_p-1:0]   pc_mem    [depth_p];

    logic [ptr_w_lp-1:0]     wptr_r, rptr_r;
    logic [cnt_w_lp-1:0]     count_r;
    logic                    empty, bypass, enq, deq;

    vanilla_decode_lite decode (
        .instr_i  (instr_i),
        .decode_o (dec_li)
    );

    assign empty   = (count_r == '0);
    assign ready_o = (count_r != cnt_w_lp'(depth_p));
    assign count_o = count_r;

`ifdef VANILLA_DECODE_BUF_BYPASS_EN
    assign bypass = empty & v_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word consumed in the same cycle never touches storage
    assign enq = v_i & ready_o & ~flush_i & ~(bypass & yumi_i);
    assign deq = yumi_i & ~empty & ~flush_i;

    // Pointer and occupancy tracking; flush dominates enqueue/dequeue
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + ptr_w_lp'(1);
            if (deq) rptr_r <= rptr_r + ptr_w_lp'(1);
            count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        end
    end

    // Tail write of decoded record, raw word and PC (contents not reset)
    always_ff @(posedge clk_i) begin
        if (enq) begin
            dec_mem[wptr_r]   <= dec_li;
            instr_mem[wptr_r] <= instr_i;
            pc_mem[wptr_r]    <= pc_i;
        end
    end

    // Head presentation from storage, or from the input when bypassing
    always_comb begin
        v_o      = ~empty | bypass;
        decode_o = dec_mem[rptr_r];
        instr_o  = instr_mem[rptr_r];
        pc_o     = pc_mem[rptr_r];
`ifdef VANILLA_DECODE_BUF_BYPASS_EN
        if (bypass) begin
            decode_o = dec_li;
            instr_o  = instr_i;
            pc_o     = pc_i;
        end
`endif
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                       yumi_i |-> v_o);

endmodule

// File: tb/tb_vanilla_decode_buffer.sv
// Randomised self-checking bench for vanilla_decode_buffer against a
// queue-based reference model with a rule-level decode function.
module tb_vanilla_decode_buffer;
    import bsg_vanilla_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PCW   = 22;
`ifdef VANILLA_DECODE_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  v_i, yumi_i, flush_i;
    logic [31:0]           instr_i;
    logic [PCW-1:0]        pc_i;
    logic                  ready_o, v_o;
    decode_lite_s          decode_o;
    logic [31:0]           instr_o;
    logic [PCW-1:0]        pc_o;
    logic [2:0]            count_o;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0]    instr;
        logic [PCW-1:0] pc;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    vanilla_decode_buffer #(.depth_p(DEPTH), .pc_width_p(PCW)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .instr_i   (instr_i),
        .pc_i      (pc_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .decode_o  (decode_o),
        .instr_o   (instr_o),
        .pc_o      (pc_o),
        .yumi_i    (yumi_i),
        .flush_i   (flush_i),
        .count_o   (count_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decode rules restated directly from the opcode tables
    function automatic decode_lite_s ref_decode(input logic [31:0] w);
        decode_lite_s d;
        logic [6:0] op, f7;
        bit fp_int;
        op = w[6:0];
        f7 = w[31:25];
        d  = '0;
        fp_int = (op == 7'b1010011) &&
                 (f7 == 7'b1010000 || (f7 == 7'b1110000 && w[24:20] == 5'd0) || f7 == 7'b1100000);
        d.writes_rf = (w[11:7] != 0 && op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                                   7'b0000011, 7'b0110011, 7'b0010011, 7'b0101111})
                      || fp_int;
        d.reads_rf1 = (op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0110011,
                                  7'b0010011, 7'b0101111, 7'b0000111, 7'b0100111})
                      || (op == 7'b1010011 && f7 inside {7'b1101000, 7'b1111000});
        d.reads_rf2 = (op inside {7'b1100011, 7'b0100011, 7'b0110011})
                      || (op == 7'b0101111 && (f7[6:2] == 5'b00001 || f7[6:2] == 5'b01000));
        d.writes_fp_rf = (op == 7'b0000111) || (op == 7'b1010011 && !d.writes_rf);
        d.is_load   = op inside {7'b0000011, 7'b0000111};
        d.is_store  = op inside {7'b0100011, 7'b0100111};
        d.is_branch = (op == 7'b1100011);
        d.is_jal    = (op == 7'b1101111);
        d.is_jalr   = (op == 7'b1100111);
        d.is_md     = (op == 7'b0110011) && (f7 == 7'b0000001);
        d.is_fence  = (op == 7'b0001111) && (w[14:12] == 3'b000);
        d.illegal   = !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                   7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0101111,
                                   7'b1010011, 7'b0000111, 7'b0100111, 7'b0001111, 7'b1110011});
        return d;
    endfunction

    function automatic bit head_valid(input bit v, input bit f);
        return (q.size() != 0) || (BYP && v && !f);
    endfunction

    // One clock: drive, sample at negedge against the model, advance the model
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [PCW-1:0] pc,
                         input bit y, input bit f);
        bit   byp_now, exp_v, can_enq;
        ent_t hd;
        v_i = v; instr_i = ins; pc_i = pc; yumi_i = y; flush_i = f;
        @(negedge clk);
        byp_now = BYP && q.size() == 0 && v && !f;
        exp_v   = head_valid(v, f);
        check_eq("ready", ready_o, q.size() != DEPTH);
        check_eq("v_o", v_o, exp_v);
        check_eq("count", count_o, q.size());
        if (exp_v) begin
            if (byp_now) begin
                hd.instr = ins; hd.pc = pc;
            end else begin
                hd = q[0];
            end
            check_eq("instr_o", instr_o, hd.instr);
            check_eq("pc_o", pc_o, hd.pc);
            check_eq("decode_o", decode_o, ref_decode(hd.instr));
        end
        @(posedge clk);
        if (f) begin
            q.delete();
        end else if (!(byp_now && y)) begin
            can_enq = q.size() != DEPTH;
            if (y && q.size() != 0) void'(q.pop_front());
            if (v && can_enq) q.push_back('{ins, pc});
        end
        #1;
        v_i = 1'b0; yumi_i = 1'b0; flush_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [15] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0101111,
                                 7'b1010011, 7'b0000111, 7'b0100111, 7'b0001111, 7'b1110011};
        logic [6:0] fpf [6] = '{7'b1010000, 7'b1110000, 7'b1100000, 7'b1101000, 7'b1111000, 7'b0000000};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(7) != 0) w[6:0] = ops[$urandom_range(14)];
        if (w[6:0] == 7'b1010011 && $urandom_range(1) == 1) w[31:25] = fpf[$urandom_range(5)];
        if (w[6:0] == 7'b1010011 && $urandom_range(1) == 1) w[24:20] = 5'd0;
        if ($urandom_range(5) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        bit v, f, y;
        reset_n = 1'b0;
        v_i = 1'b0; instr_i = '0; pc_i = '0; yumi_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", ready_o, 1);
        check_eq("rst_v", v_o, 0);
        check_eq("rst_count", count_o, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // addi x1,x0,5 at PC 0x10
        cycle(1, 32'h00500093, 22'h10, 0, 0);
        check_eq("addi_v", v_o, 1);
        check_eq("addi_wrf", decode_o.writes_rf, 1);
        check_eq("addi_rf1", decode_o.reads_rf1, 1);
        check_eq("addi_rf2", decode_o.reads_rf2, 0);
        check_eq("addi_pc", pc_o, 22'h10);
        cycle(0, 0, 0, 1, 0);

        // fill to full, try one more, then drain in order
        for (int i = 0; i < 4; i++) cycle(1, 32'h00100093 + (i << 20), PCW'(32'h100 + i*4), 0, 0);
        check_eq("full_ready", ready_o, 0);
        check_eq("full_count", count_o, 4);
        cycle(1, 32'h00000013, 22'h999, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        check_eq("drained_v", v_o, 0);

        // steady state at 3 entries with wrapping pointers
        for (int i = 0; i < 3; i++) cycle(1, rand_instr(), PCW'(32'h200 + i), 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, rand_instr(), PCW'(32'h300 + i), 1, 0);
        check_eq("steady_count", count_o, 3);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

        // flush with a concurrent enqueue
        for (int i = 0; i < 2; i++) cycle(1, rand_instr(), PCW'(32'h400 + i), 0, 0);
        cycle(1, 32'h00500093, 22'h444, 0, 1);
        check_eq("flush_count", count_o, 0);
        check_eq("flush_v", v_o, 0);
        check_eq("flush_ready", ready_o, 1);

        // illegal word, then sw
        cycle(1, 32'hFFFFFFFF, 22'h500, 0, 0);
        check_eq("ill_illegal", decode_o.illegal, 1);
        cycle(1, 32'h00112023, 22'h504, 1, 0);
        check_eq("sw_store", decode_o.is_store, 1);
        check_eq("sw_rf2", decode_o.reads_rf2, 1);
        check_eq("sw_wrf", decode_o.writes_rf, 0);
        cycle(0, 0, 0, 1, 0);

`ifdef VANILLA_DECODE_BUF_BYPASS_EN
        cycle(1, 32'h00500093, 22'h600, 1, 0);
        check_eq("byp_count", count_o, 0);
        check_eq("byp_v_after", v_o, 0);
`endif

        // asynchronous reset in the middle of filling
        for (int i = 0; i < 2; i++) cycle(1, rand_instr(), PCW'(32'h700 + i), 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_count", count_o, 0);
        check_eq("arst_v", v_o, 0);
        check_eq("arst_ready", ready_o, 1);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(3) != 0);
            f = ($urandom_range(24) == 0);
            y = head_valid(v, f) && ($urandom_range(2) != 0);
            cycle(v, rand_instr(), PCW'($urandom), y, f);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
